// File: rtl/rom_stepper_pkg.sv
// Shared types and widths for the ROM stepper (package rom_pkg).
package rom_pkg;
  localparam int ADR_W_DEF = 4;
  localparam int DAT_W_DEF = 8;
  localparam int CNT_W     = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;
endpackage

// File: rtl/rom_stepper_sw_edge.sv
// Rising-edge detector for the debounced switch; the history flop resets high
// so a switch already held through reset does not register as a press.
module sw_edge
  import rom_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sw,
  output logic o_press
);
  logic r_sw_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_sw_q <= 1'b1;
    else       r_sw_q <= i_sw;
  end

  assign o_press = i_sw & ~r_sw_q;
endmodule

// File: rtl/rom_stepper.sv
// Steps a ROM address once per switch press and registers the fetched byte.
// Optional auto-repeat while held: define ROM_STEPPER_AUTO_REPEAT_EN.
//
// state | meaning
// IDLE  | waiting for a fresh press
// FETCH | capture rom data, pulse valid
// HOLD  | switch still held after fetch; wait for release (or auto-repeat)
module rom_stepper
  import rom_pkg::*;
#(
  parameter int               ADR_W         = ADR_W_DEF,
  parameter int               DAT_W         = DAT_W_DEF,
  parameter int               LAST_ADR      = 15,
  parameter logic [CNT_W-1:0] HOLD_CYCLES   = 24'd5_000_000,
  parameter logic [CNT_W-1:0] REPEAT_CYCLES = 24'd1_000_000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_sw_in,
  output logic [ADR_W-1:0] o_adr,
  input  logic [DAT_W-1:0] i_rom_dat,
  output logic [DAT_W-1:0] o_dat_out,
  output logic             o_dat_valid,
  output logic             o_wrap
);
  localparam logic [ADR_W-1:0] LAST = ADR_W'(LAST_ADR);

  state_t           r_state;
  logic [ADR_W-1:0] r_adr;
  logic [DAT_W-1:0] r_dat;
  logic             r_valid;
  logic             r_wrap;
  logic             w_press;
  logic             w_at_last;
  logic [ADR_W-1:0] w_adr_next;

  sw_edge u_sw_edge (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_sw    (i_sw_in),
    .o_press (w_press)
  );

  assign w_at_last  = (r_adr == LAST);
  assign w_adr_next = w_at_last ? '0 : r_adr + 1'b1;

`ifdef ROM_STEPPER_AUTO_REPEAT_EN
  logic [CNT_W-1:0] r_cnt;
  logic             r_repeating;
  logic             w_cnt_hit;

  assign w_cnt_hit = (r_cnt == (r_repeating ? REPEAT_CYCLES - 1'b1 : HOLD_CYCLES - 1'b1));

  // Counter restarts on every entry to HOLD; repeating survives a repeat FETCH.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt       <= '0;
      r_repeating <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt       <= '0;
          r_repeating <= 1'b0;
        end
        FETCH: begin
          r_cnt <= '0;
          if (!i_sw_in) r_repeating <= 1'b0;
        end
        HOLD: begin
          if (!i_sw_in)       r_repeating <= 1'b0;
          else if (w_cnt_hit) r_repeating <= 1'b1;
          else                r_cnt       <= r_cnt + 1'b1;
        end
        default: begin
          r_cnt       <= '0;
          r_repeating <= 1'b0;
        end
      endcase
    end
  end
`else
  // Repeat timing only matters with auto-repeat compiled in.
  if (HOLD_CYCLES == '0 && REPEAT_CYCLES == '0) begin : g_repeat_timing_unused
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= FETCH;
      r_adr   <= '0;
      r_dat   <= '0;
      r_valid <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_wrap  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_press) begin
            r_adr   <= w_adr_next;
            r_wrap  <= w_at_last;
            r_state <= FETCH;
          end
        end
        FETCH: begin
          r_dat   <= i_rom_dat;
          r_valid <= 1'b1;
          r_state <= i_sw_in ? HOLD : IDLE;
        end
        HOLD: begin
          if (!i_sw_in) begin
            r_state <= IDLE;
`ifdef ROM_STEPPER_AUTO_REPEAT_EN
          end else if (w_cnt_hit) begin
            r_adr   <= w_adr_next;
            r_wrap  <= w_at_last;
            r_state <= FETCH;
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_adr       = r_adr;
  assign o_dat_out   = r_dat;
  assign o_dat_valid = r_valid;
  assign o_wrap      = r_wrap;
endmodule

// File: tb/tb_rom_stepper.sv
// Scoreboard bench for rom_stepper: presses are modelled as address steps and
// pushed as expected fetches; a monitor pops one entry per dat_valid pulse.
module tb_rom_stepper;
  localparam int LAST   = 15;
  localparam int HOLD_C = 10;
  localparam int REP_C  = 4;

  typedef struct packed {
    logic [3:0] adr;
    logic [7:0] dat;
    logic       wrap;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       sw_in;
  logic [3:0] adr;
  logic [7:0] rom_dat;
  logic [7:0] dat_out;
  logic       dat_valid;
  logic       wrap;

  logic [7:0] rom [16];
  exp_t       exp_q [$];
  int         n_cmp  = 0;
  int         n_fail = 0;
  int         model_adr = 0;
  bit         done = 1'b0;

  always #5 clk = ~clk;
  assign rom_dat = rom[adr];

  rom_stepper #(
    .LAST_ADR      (LAST),
    .HOLD_CYCLES   (24'(HOLD_C)),
    .REPEAT_CYCLES (24'(REP_C))
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_sw_in     (sw_in),
    .o_adr       (adr),
    .i_rom_dat   (rom_dat),
    .o_dat_out   (dat_out),
    .o_dat_valid (dat_valid),
    .o_wrap      (wrap)
  );

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic push_fetch(input int a, input bit w);
    exp_t e;
    e.adr  = 4'(a);
    e.dat  = rom[a];
    e.wrap = w;
    exp_q.push_back(e);
  endtask

  // One accepted step: next address with wrap past LAST, then its fetch.
  task automatic do_step();
    bit w;
    w = (model_adr == LAST);
    model_adr = w ? 0 : model_adr + 1;
    push_fetch(model_adr, w);
  endtask

  // Called at a negedge with the FSM idle; switch is high for h edges.
  task automatic press(input int h, input int l);
    sw_in = 1'b1;
    do_step();
`ifdef ROM_STEPPER_AUTO_REPEAT_EN
    for (int k = HOLD_C + 1; k <= h - 1; k += REP_C + 1) do_step();
`endif
    repeat (h) @(negedge clk);
    sw_in = 1'b0;
    repeat (l) @(negedge clk);
  endtask

  task automatic do_reset(input bit sw_level);
    sw_in = sw_level;
    rst   = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_adr",   int'(adr), 0);
    check("rst_dat",   int'(dat_out), 0);
    check("rst_valid", int'(dat_valid), 0);
    check("rst_wrap",  int'(wrap), 0);
    model_adr = 0;
    push_fetch(0, 1'b0);
    rst = 1'b0;
  endtask

  // Monitor: each dat_valid must match the oldest expected fetch; wrap must
  // have pulsed exactly in the cycle before a fetch that follows a wrap step.
  bit prev_wrap  = 1'b0;
  bit prev_valid = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (dat_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("fetch_adr",  int'(adr), int'(e.adr));
          check("fetch_dat",  int'(dat_out), int'(e.dat));
          check("fetch_wrap", int'(prev_wrap), int'(e.wrap));
        end
        if (prev_valid) check("valid_one_cycle", 1, 0);
      end else if (prev_wrap) begin
        check("orphan_wrap", 1, 0);
      end
    end
    prev_wrap  = wrap;
    prev_valid = dat_valid;
  end

  initial begin
    #500000;
    if (!done) begin
      n_fail++;
      $display("FAIL timeout: run did not complete, %0d fetches outstanding", exp_q.size());
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
    rom[0] = 8'h51;
    rom[1] = 8'hA3;
    rst    = 1'b1;
    sw_in  = 1'b0;
    @(negedge clk);

    // Reset release shows ROM[0] one edge later.
    do_reset(1'b0);
    @(posedge clk); #1;
    check("post_rst_valid", int'(dat_valid), 1);
    check("post_rst_dat",   int'(dat_out), 8'h51);
    repeat (3) @(negedge clk);

    // Single press: adr one edge after press, data one edge after that.
    sw_in = 1'b1;
    do_step();
    @(posedge clk); #1;
    check("press_adr",       int'(adr), 1);
    check("press_valid_lat", int'(dat_valid), 0);
    @(posedge clk); #1;
    check("press_dat",   int'(dat_out), 8'hA3);
    check("press_valid", int'(dat_valid), 1);
    repeat (9) @(negedge clk);
    check("held_no_step", int'(adr), 1);
    sw_in = 1'b0;
    repeat (2) @(negedge clk);

    // Random press/release patterns, enough to wrap more than once.
    for (int i = 0; i < 40; i++)
      press(int'($urandom_range(1, 25)), int'($urandom_range(1, 5)));
    repeat (3) @(negedge clk);

    // Reset in the FETCH cycle of the step to adr 5.
    do_reset(1'b0);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) press(2, 2);
    sw_in = 1'b1;
    @(posedge clk); #1;
    check("midrst_adr5", int'(adr), 5);
    @(negedge clk);
    rst   = 1'b1;
    sw_in = 1'b0;
    @(posedge clk); #1;
    check("midrst_dat_cleared", int'(dat_out), 0);
    check("midrst_adr_cleared", int'(adr), 0);
    @(negedge clk);
    model_adr = 0;
    push_fetch(0, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_rom0", int'(dat_out), 8'h51);
    repeat (3) @(negedge clk);

    // Switch held through reset is not a press.
    do_reset(1'b1);
    repeat (10) @(negedge clk);
    check("held_thru_rst_adr", int'(adr), 0);
    sw_in = 1'b0;
    repeat (2) @(negedge clk);
    press(3, 2);
    check("repress_adr", int'(adr), 1);

    // Long hold and release exactly on the first repeat threshold.
    press(30, 3);
    press(HOLD_C + 1, 3);
    press(HOLD_C + 1 + REP_C + 1, 3);
    repeat (5) @(negedge clk);
    check("final_adr", int'(adr), model_adr);
    check("queue_drained", exp_q.size(), 0);

    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
